// File: rtl/countdown_pkg.sv
// Shared types for the loadable countdown timer: FSM states and the
// next-count select used between the control FSM and the datapath.
package countdown_pkg;

  localparam int CD_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cd_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_LOAD   = 3'd1,
    SEL_DEC    = 3'd2,
    SEL_RELOAD = 3'd3,
    SEL_ZERO   = 3'd4
  } cnt_sel_t;

endpackage

// File: rtl/countdown_datapath.sv
// Combinational next-count mux for the countdown timer, plus the
// count==1 / count==0 flags the control FSM decides on.
module countdown_datapath
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] reload,
  input  cnt_sel_t         sel,
  output logic [WIDTH-1:0] count_next,
  output logic             is_one,
  output logic             is_zero
);

  always_comb begin
    count_next = count;
    case (sel)
      SEL_HOLD:   count_next = count;
      SEL_LOAD:   count_next = d;
      SEL_DEC:    count_next = count - WIDTH'(1);
      SEL_RELOAD: count_next = reload;
      SEL_ZERO:   count_next = '0;
      default:    count_next = count;
    endcase
  end

  assign is_one  = (count == WIDTH'(1));
  assign is_zero = (count == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control, one-cycle terminal
// count pulse and optional auto-reload. All outputs come from flops.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] qout,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  cnt_sel_t         sel;
  logic             is_one, is_zero;
  logic             reload_zero;

  assign reload_zero = (reload_q == '0);

  countdown_datapath #(.WIDTH(WIDTH)) u_datapath (
    .count      (count_q),
    .d          (d),
    .reload     (reload_q),
    .sel        (sel),
    .count_next (count_d),
    .is_one     (is_one),
    .is_zero    (is_zero)
  );

  // Priority: load, then start, then en. tc_d only rises on a terminal event.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    sel      = SEL_HOLD;
    tc_d     = 1'b0;
    if (load) begin
      sel      = SEL_LOAD;
      reload_d = d;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_zero) begin
              state_d = DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (en && is_one) begin
            tc_d = 1'b1;
            if (auto_reload && !reload_zero) begin
              sel = SEL_RELOAD;
            end else begin
              sel     = SEL_ZERO;
              state_d = DONE;
            end
          end else if (en && !is_zero) begin
            sel = SEL_DEC;
          end
        end
        DONE: begin
          if (start) begin
            if (!reload_zero) begin
              sel     = SEL_RELOAD;
              state_d = RUN;
            end else begin
              tc_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign qout = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (WIDTH=8): vector table plus a long
// randomised-enable countdown, checked through an expected-value queue.
module tb_countdown_timer;

  localparam int W  = 8;
  localparam int EW = W + 3;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] d;
  logic         start;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] qout;
  logic         tc;
  logic         busy;
  logic         done;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .d           (d),
    .start       (start),
    .en          (en),
    .auto_reload (auto_reload),
    .qout        (qout),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic         ld;
    logic [W-1:0] dv;
    logic         st;
    logic         e;
    logic         ar;
    logic [W-1:0] q;
    logic         t;
    logic         b;
    logic         dn;
    string        name;
  } vec_t;

  vec_t            vecs[$];
  logic [EW-1:0]   exp_q[$];
  string           name_q[$];
  int              checks   = 0;
  int              failures = 0;

  function automatic void add(input logic r, ld, input int dv, input logic st, e, ar,
                              input int q, input logic t, b, dn, input string name);
    vec_t v;
    v.r = r; v.ld = ld; v.dv = W'(dv); v.st = st; v.e = e; v.ar = ar;
    v.q = W'(q); v.t = t; v.b = b; v.dn = dn; v.name = name;
    vecs.push_back(v);
  endfunction

  // driver: apply one cycle of inputs and queue the expected post-edge outputs
  task automatic step(input logic r, ld, input logic [W-1:0] dv, input logic st, e, ar,
                      input logic [EW-1:0] exp, input string name);
    @(negedge clk);
    reset = r; load = ld; d = dv; start = st; en = e; auto_reload = ar;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    scoreboard_check();
  endtask

  // scoreboard: pop the oldest expectation and compare against the DUT
  task automatic scoreboard_check();
    logic [EW-1:0] exp;
    logic [EW-1:0] act;
    string         nm;
    if (exp_q.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_underflow: no expected entry queued");
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    act = {qout, tc, busy, done};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got qout=%0d tc=%b busy=%b done=%b, want qout=%0d tc=%b busy=%b done=%b",
               nm, act[EW-1:3], act[2], act[1], act[0], exp[EW-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    int enabled;
    int cycles;
    int exp_cnt;

    reset = 1'b1; load = 1'b0; d = '0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;

    //   r  ld  d  st e  ar   q  tc b  dn
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, "reset_state");
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "idle_hold");
    // basic countdown from 4
    add(0, 1, 4, 0, 0, 0,   4, 0, 0, 0, "load4");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, 0, "start4");
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, "dec3");
    add(0, 0, 0, 0, 1, 0,   2, 0, 1, 0, "dec2");
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0, "dec1");
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, "terminal4");
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, "done_hold");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, 0, "done_restart");
    // reset mid-RUN with qout=5
    add(0, 1, 5, 0, 0, 0,   5, 0, 0, 0, "load5");
    add(0, 0, 0, 1, 0, 0,   5, 0, 1, 0, "start5");
    add(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, "reset_mid_run");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 1, "start_zero_after_reset");
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, "tc_single_pulse");
    // auto-reload period 3, ten enabled cycles
    add(0, 1, 3, 0, 0, 1,   3, 0, 0, 0, "load3");
    add(0, 0, 0, 1, 0, 1,   3, 0, 1, 0, "start3");
    add(0, 0, 0, 0, 1, 1,   2, 0, 1, 0, "ar_c1");
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 0, "ar_c2");
    add(0, 0, 0, 0, 1, 1,   3, 1, 1, 0, "ar_c3");
    add(0, 0, 0, 0, 1, 1,   2, 0, 1, 0, "ar_c4");
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 0, "ar_c5");
    add(0, 0, 0, 0, 1, 1,   3, 1, 1, 0, "ar_c6");
    add(0, 0, 0, 0, 1, 1,   2, 0, 1, 0, "ar_c7");
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 0, "ar_c8");
    add(0, 0, 0, 0, 1, 1,   3, 1, 1, 0, "ar_c9");
    add(0, 0, 0, 0, 1, 1,   2, 0, 1, 0, "ar_c10");
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0, "ar_off_c1");
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, "ar_off_terminal");
    // enable toggling, start ignored in RUN
    add(0, 1, 6, 0, 0, 0,   6, 0, 0, 0, "load6");
    add(0, 0, 0, 1, 0, 0,   6, 0, 1, 0, "start6");
    add(0, 0, 0, 0, 1, 0,   5, 0, 1, 0, "en1");
    add(0, 0, 0, 1, 0, 0,   5, 0, 1, 0, "en0_start_ignored");
    add(0, 0, 0, 0, 0, 0,   5, 0, 1, 0, "en0_hold");
    add(0, 0, 0, 0, 1, 0,   4, 0, 1, 0, "en1_again");
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, "down3");
    add(0, 0, 0, 0, 1, 0,   2, 0, 1, 0, "down2");
    // load beats start mid-RUN
    add(0, 1, 9, 1, 1, 0,   9, 0, 0, 0, "load_wins");
    add(0, 0, 0, 1, 0, 0,   9, 0, 1, 0, "start9");
    add(0, 0, 0, 0, 1, 0,   8, 0, 1, 0, "dec8");
    // zero load: immediate DONE, restart in DONE with reload 0
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, "load0");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 1, "start0");
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, "done0_hold");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 1, "restart0");
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, "done0_hold2");
    // reload=1 with auto-reload: tc every enabled cycle, held when en=0
    add(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, "load1");
    add(0, 0, 0, 1, 0, 1,   1, 0, 1, 0, "start1");
    add(0, 0, 0, 0, 1, 1,   1, 1, 1, 0, "r1_tc_a");
    add(0, 0, 0, 0, 1, 1,   1, 1, 1, 0, "r1_tc_b");
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, "r1_hold");
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, "r1_final");

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].ld, vecs[i].dv, vecs[i].st, vecs[i].e, vecs[i].ar,
           {vecs[i].q, vecs[i].t, vecs[i].b, vecs[i].dn}, vecs[i].name);
    end

    // full-range count: 255 enabled cycles with random gaps in en
    step(0, 1, W'(255), 0, 0, 0, {W'(255), 3'b000}, "load255");
    step(0, 0, '0, 1, 0, 0, {W'(255), 3'b010}, "start255");
    enabled = 0;
    cycles  = 0;
    while (enabled < 255 && cycles < 2000) begin
      logic e;
      e = 1'($urandom_range(0, 3) != 0);
      if (e) enabled++;
      exp_cnt = 255 - enabled;
      if (exp_cnt == 0)
        step(0, 0, '0, $urandom_range(0, 1) == 1, e, 0, {W'(0), 3'b101}, "full_terminal");
      else
        step(0, 0, '0, $urandom_range(0, 1) == 1, e, 1'($urandom_range(0, 1)),
             {W'(exp_cnt), 3'b010}, "full_count");
      cycles++;
    end
    checks++;
    if (enabled != 255) begin
      failures++;
      $display("FAIL full_count_budget: got enabled=%0d, want 255", enabled);
    end
    step(0, 0, '0, 0, 1, 0, {W'(0), 3'b001}, "full_done_hold");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
